// File: rtl/vga_pkg.sv
// Shared types and default geometry for the VGA digit scheduler.
// Slot pitch times digit count fills the 448-pixel number zone.
package vga_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_VBLANK,
        S_WAIT_ZONE,
        S_IN_ZONE
    } state_t;

    localparam int VBLANK_ROW     = 481;
    localparam int DEF_NUM_DIGITS = 8;
    localparam int DEF_DIGIT_W    = 42;
    localparam int DEF_SLOT_W     = 56;
    localparam int DEF_DIGIT_H    = 70;

    function automatic int idx_w(int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lz_mask.sv
// Leading-zero blanking mask: slot k is hidden when every digit
// from the leftmost slot up to k is zero. The last slot always shows.
module lz_mask #(
    parameter int NUM_DIGITS = 8
) (
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic                    blank,
    output logic [NUM_DIGITS-1:0]   mask
);

    logic all_zero;

    always_comb begin
        mask     = '0;
        all_zero = blank;
        for (int k = 0; k < NUM_DIGITS - 1; k++) begin
            all_zero = all_zero &&
                       (digits[4*(NUM_DIGITS-1-k) +: 4] == 4'd0);
            mask[k]  = all_zero;
        end
    end

endmodule

// File: rtl/vga_digit_scheduler.sv
// Schedules BCD digit glyphs across the number zone, committing
// new display values only during vertical blank.
module vga_digit_scheduler #(
    parameter int NUM_DIGITS = vga_pkg::DEF_NUM_DIGITS,
    parameter int DIGIT_W    = vga_pkg::DEF_DIGIT_W,
    parameter int SLOT_W     = vga_pkg::DEF_SLOT_W,
    parameter int DIGIT_H    = vga_pkg::DEF_DIGIT_H,
    parameter int VBLANK_ROW = vga_pkg::VBLANK_ROW
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    write_zone,
    input  logic [9:0]              count1,
    input  logic                    upd_valid,
    input  logic [4*NUM_DIGITS-1:0] upd_digits,
    input  logic                    blank_lz,
    output logic                    upd_ready,
    output logic [3:0]              digit_code,
    output logic [5:0]              glyph_x,
    output logic [6:0]              glyph_y,
    output logic                    glyph_en,
    output logic                    frame_start
);

    import vga_pkg::*;

    localparam int SW = idx_w(NUM_DIGITS);

    localparam logic [9:0]    VB_ROW    = 10'(VBLANK_ROW);
    localparam logic [5:0]    DW        = 6'(DIGIT_W);
    localparam logic [5:0]    DW_M1     = 6'(DIGIT_W - 1);
    localparam logic [5:0]    SLOT_M1   = 6'(SLOT_W - 1);
    localparam logic [SW-1:0] SLOT_LAST = SW'(NUM_DIGITS - 1);
    localparam logic [6:0]    DH_M1     = 7'(DIGIT_H - 1);

    state_t state, state_n;

    logic [4*NUM_DIGITS-1:0] pending, display;
    logic                    pend_full;
    logic [NUM_DIGITS-1:0]   mask, mask_n;
    logic [5:0]              x, x_n, gx_n;
    logic [SW-1:0]           slot, slot_n;
    logic [6:0]              gy;
    logic [3:0]              nib;
    logic                    vb_row, vb_entry, fs_n;
    logic                    zone_n, en_n;

    assign vb_row    = (count1 >= VB_ROW);
    assign upd_ready = ~pend_full;
    assign glyph_y   = gy;

    lz_mask #(
        .NUM_DIGITS(NUM_DIGITS)
    ) u_lz_mask (
        .digits(pending),
        .blank (blank_lz),
        .mask  (mask_n)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        fs_n    = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (vb_row) state_n = S_VBLANK;
            end
            S_VBLANK: begin
                if (!vb_row) begin
                    state_n = S_WAIT_ZONE;
                    fs_n    = 1'b1;
                end
            end
            S_WAIT_ZONE: begin
                if (vb_row)          state_n = S_VBLANK;
                else if (write_zone) state_n = S_IN_ZONE;
            end
            S_IN_ZONE: begin
                if (!write_zone) state_n = S_WAIT_ZONE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign vb_entry = (state != S_VBLANK) && (state_n == S_VBLANK);
    assign zone_n   = (state_n == S_IN_ZONE);

    // Counters are advanced here so the pixel registers see the
    // position of the pixel whose write_zone sample is being taken.
    always_comb begin
        x_n    = x;
        slot_n = slot;
        if (state == S_WAIT_ZONE && state_n == S_IN_ZONE) begin
            x_n    = '0;
            slot_n = '0;
        end else if (state == S_IN_ZONE) begin
            if (x == SLOT_M1) begin
                x_n = '0;
                if (slot != SLOT_LAST) slot_n = slot + 1'b1;
            end else begin
                x_n = x + 1'b1;
            end
        end
    end

    always_comb begin
        nib = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (slot_n == SW'(k)) nib = display[4*(NUM_DIGITS-1-k) +: 4];
        end
        gx_n = (x_n >= DW) ? DW_M1 : x_n;
        en_n = zone_n && (x_n < DW) && !mask[slot_n];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x           <= '0;
            slot        <= '0;
            gy          <= '0;
            glyph_en    <= 1'b0;
            digit_code  <= '0;
            glyph_x     <= '0;
            frame_start <= 1'b0;
        end else begin
            x           <= x_n;
            slot        <= slot_n;
            glyph_en    <= en_n;
            digit_code  <= zone_n ? nib : 4'd0;
            glyph_x     <= zone_n ? gx_n : 6'd0;
            frame_start <= fs_n;
            if (state == S_VBLANK) begin
                gy <= '0;
            end else if (state == S_IN_ZONE && state_n == S_WAIT_ZONE) begin
                gy <= (gy == DH_M1) ? 7'd0 : gy + 1'b1;
            end
        end
    end

    // Commit and accept are exclusive: accept needs pending empty.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending   <= '0;
            pend_full <= 1'b0;
            display   <= '0;
            mask      <= '0;
        end else if (vb_entry && pend_full) begin
            display   <= pending;
            mask      <= mask_n;
            pending   <= '0;
            pend_full <= 1'b0;
        end else if (upd_valid && !pend_full) begin
            pending   <= upd_digits;
            pend_full <= 1'b1;
        end
    end

endmodule

// File: tb/tb_vga_digit_scheduler.sv
// Scoreboard bench for vga_digit_scheduler: expected pixels are
// queued as write_zone is driven and compared one cycle later.
module tb_vga_digit_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        write_zone = 1'b0;
    logic [9:0]  count1 = '0;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_digits = '0;
    logic        blank_lz = 1'b0;
    logic        upd_ready;
    logic [3:0]  digit_code;
    logic [5:0]  glyph_x;
    logic [6:0]  glyph_y;
    logic        glyph_en;
    logic        frame_start;

    always #5 clk = ~clk;

    vga_digit_scheduler dut (
        .clk        (clk),
        .reset      (reset),
        .write_zone (write_zone),
        .count1     (count1),
        .upd_valid  (upd_valid),
        .upd_digits (upd_digits),
        .blank_lz   (blank_lz),
        .upd_ready  (upd_ready),
        .digit_code (digit_code),
        .glyph_x    (glyph_x),
        .glyph_y    (glyph_y),
        .glyph_en   (glyph_en),
        .frame_start(frame_start)
    );

    typedef struct packed {
        logic       en;
        logic [3:0] code;
        logic [5:0] gx;
        logic [6:0] gy;
    } pix_t;

    pix_t sb[$];

    int n_tests = 0;
    int n_fail  = 0;
    int fs_seen = 0;

    logic [3:0]  m_disp[8];
    logic        m_mask[8];
    logic [31:0] m_pend;
    logic        m_pend_full;
    logic        m_active;
    int          m_gy;

    task automatic step();
        @(posedge clk);
        #1;
        if (frame_start === 1'b1) fs_seen++;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 8; k++) begin
            m_disp[k] = 4'd0;
            m_mask[k] = 1'b0;
        end
        m_pend      = '0;
        m_pend_full = 1'b0;
        m_active    = 1'b0;
        m_gy        = 0;
        sb.delete();
    endtask

    task automatic model_commit();
        logic zero;
        for (int k = 0; k < 8; k++) m_disp[k] = m_pend[4*(7-k) +: 4];
        zero = blank_lz;
        for (int k = 0; k < 7; k++) begin
            zero      = zero && (m_disp[k] == 4'd0);
            m_mask[k] = zero;
        end
        m_mask[7]   = 1'b0;
        m_pend_full = 1'b0;
    endtask

    task automatic send(input logic [31:0] word);
        upd_valid  = 1'b1;
        upd_digits = word;
        step();
        upd_valid  = 1'b0;
        m_pend      = word;
        m_pend_full = 1'b1;
        n_tests++;
        if (upd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL send_ready got %b expected 0", upd_ready);
        end
    endtask

    task automatic vblank(input logic offer, input logic [31:0] word);
        int fs0;
        fs0    = fs_seen;
        count1 = 10'd481;
        if (offer) begin
            upd_valid  = 1'b1;
            upd_digits = word;
        end
        step();
        if (m_pend_full) model_commit();
        else if (offer) begin
            m_pend      = word;
            m_pend_full = 1'b1;
        end
        upd_valid = 1'b0;
        n_tests++;
        if (upd_ready !== !m_pend_full) begin
            n_fail++;
            $display("FAIL vblank_ready got %b expected %b",
                     upd_ready, !m_pend_full);
        end
        step();
        count1 = 10'd100;
        step();
        n_tests++;
        if (frame_start !== 1'b1) begin
            n_fail++;
            $display("FAIL frame_start_pulse got %b expected 1", frame_start);
        end
        step();
        n_tests++;
        if (fs_seen - fs0 != 1) begin
            n_fail++;
            $display("FAIL frame_start_count got %0d expected 1", fs_seen - fs0);
        end
        m_active = 1'b1;
        m_gy     = 0;
    endtask

    task automatic run_line(input int len, output int en_cnt);
        pix_t e, got;
        en_cnt     = 0;
        write_zone = 1'b1;
        for (int i = 0; i < len; i++) begin
            int s, x;
            s = i / 56;
            if (s > 7) s = 7;
            x = i % 56;
            e.en   = m_active && (x < 42) && !m_mask[s];
            e.code = m_active ? m_disp[s] : 4'd0;
            e.gx   = m_active ? 6'((x >= 42) ? 41 : x) : 6'd0;
            e.gy   = 7'(m_gy);
            sb.push_back(e);
            step();
            got = {glyph_en, digit_code, glyph_x, glyph_y};
            e   = sb.pop_front();
            if (glyph_en === 1'b1) en_cnt++;
            n_tests++;
            if (got !== e) begin
                n_fail++;
                if (n_fail < 40)
                    $display("FAIL pixel[%0d] got en=%b code=%0d x=%0d y=%0d expected en=%b code=%0d x=%0d y=%0d",
                             i, got.en, got.code, got.gx, got.gy,
                             e.en, e.code, e.gx, e.gy);
            end
        end
        write_zone = 1'b0;
        step();
        if (m_active) m_gy = (m_gy + 1) % 70;
        n_tests++;
        if (glyph_en !== 1'b0 || glyph_y !== 7'(m_gy)) begin
            n_fail++;
            $display("FAIL line_end got en=%b y=%0d expected en=0 y=%0d",
                     glyph_en, glyph_y, m_gy);
        end
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        model_reset();
        #1;
        n_tests++;
        if ({glyph_en, digit_code, glyph_x, glyph_y, frame_start, upd_ready}
            !== 20'h00001) begin
            n_fail++;
            $display("FAIL reset_outputs got en=%b code=%0d x=%0d y=%0d fs=%b rdy=%b expected zeros rdy=1",
                     glyph_en, digit_code, glyph_x, glyph_y, frame_start, upd_ready);
        end
        write_zone = 1'b1;
        step();
        step();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            n_tests++;
            if (glyph_en !== 1'b0 || frame_start !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_ignores_zone got en=%b fs=%b expected 0 0",
                         glyph_en, frame_start);
            end
        end
        write_zone = 1'b0;
        step();
    endtask

    task automatic test_update();
        int cnt;
        blank_lz = 1'b0;
        send(32'h12345678);
        upd_valid  = 1'b1;
        upd_digits = 32'hDEADBEEF;
        step();
        upd_valid = 1'b0;
        vblank(1'b0, '0);
        run_line(448, cnt);
    endtask

    task automatic test_burst();
        int cnt;
        run_line(448, cnt);
        n_tests++;
        if (cnt != 336) begin
            n_fail++;
            $display("FAIL burst_en_count got %0d expected 336", cnt);
        end
    endtask

    task automatic test_leading_zero();
        int cnt;
        blank_lz = 1'b1;
        send(32'h00000450);
        vblank(1'b0, '0);
        run_line(448, cnt);
        n_tests++;
        if (cnt != 126) begin
            n_fail++;
            $display("FAIL lz_en_count got %0d expected 126", cnt);
        end
    endtask

    task automatic test_all_zero();
        int cnt;
        blank_lz = 1'b1;
        send(32'h00000000);
        vblank(1'b0, '0);
        run_line(448, cnt);
        n_tests++;
        if (cnt != 42) begin
            n_fail++;
            $display("FAIL all_zero_en_count got %0d expected 42", cnt);
        end
        blank_lz = 1'b0;
    endtask

    task automatic test_glyph_y();
        int cnt, fs0;
        send(32'h87654321);
        vblank(1'b0, '0);
        fs0 = fs_seen;
        for (int l = 0; l < 70; l++) run_line(60, cnt);
        n_tests++;
        if (glyph_y !== 7'd0) begin
            n_fail++;
            $display("FAIL glyph_y_wrap got %0d expected 0", glyph_y);
        end
        run_line(60, cnt);
        vblank(1'b0, '0);
        n_tests++;
        if (fs_seen - fs0 != 1) begin
            n_fail++;
            $display("FAIL frame_pulses got %0d expected 1", fs_seen - fs0);
        end
    endtask

    task automatic test_commit_cycle();
        int cnt;
        vblank(1'b1, 32'h11223344);
        run_line(448, cnt);
        vblank(1'b0, '0);
        run_line(448, cnt);
    endtask

    task automatic test_mid_frame_reset();
        int cnt;
        send(32'h99999999);
        write_zone = 1'b1;
        for (int i = 0; i < 5; i++) step();
        reset = 1'b1;
        #1;
        n_tests++;
        if ({glyph_en, digit_code, glyph_x, glyph_y, frame_start, upd_ready}
            !== 20'h00001) begin
            n_fail++;
            $display("FAIL async_reset got en=%b code=%0d x=%0d y=%0d fs=%b rdy=%b expected zeros rdy=1",
                     glyph_en, digit_code, glyph_x, glyph_y, frame_start, upd_ready);
        end
        model_reset();
        write_zone = 1'b0;
        step();
        step();
        reset = 1'b0;
        run_line(100, cnt);
        vblank(1'b0, '0);
        run_line(448, cnt);
        n_tests++;
        if (cnt != 336) begin
            n_fail++;
            $display("FAIL post_reset_en_count got %0d expected 336", cnt);
        end
    endtask

    initial begin
        test_reset();
        test_update();
        test_burst();
        test_leading_zero();
        test_all_zero();
        test_glyph_y();
        test_commit_cycle();
        test_mid_frame_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
